// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
//   - arb_state_e : FSM state encoding (IDLE, BUSY_I, BUSY_D, RESP)
//   - AW_DEF/DW_DEF : default address/data widths
//   - STREAK_W : width of the consecutive-D-grant streak counter
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the core-side (fetch + data) and memory-side signals
// of the arbiter.
//   slave  modport : the arbiter's view (serves core requests, drives memory)
//   master modport : the environment's view (core requesters + memory model)
//
// Handshake semantics (both core ports and the memory port):
//   A requester raises *_req with stable fields and holds it until the
//   matching *_ready pulse. *_ready is a one-cycle pulse that completes the
//   access; read data is valid only during that pulse. Dropping *_req before
//   the grant withdraws the request; changing fields while *_req is high is
//   not allowed.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // instruction fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  // data port
  logic          d_req;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  // memory port
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ready, i_rdata, d_ready, d_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ready, i_rdata, d_ready, d_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_perf_cnt.sv
// arb_perf_cnt: performance counters for mem_arbiter (built only when
// MEM_ARBITER_PERF_EN is defined).
//   clk, rst       : clock, synchronous active-high reset (clears counters)
//   i_inst_grant   : one-cycle strobe on each instruction-fetch grant
//   i_data_grant   : one-cycle strobe on each data grant
//   i_wait_cycle   : memory request outstanding and not completed this cycle
//   o_i_grants     : fetch grant count   (wraps mod 2^32)
//   o_d_grants     : data grant count    (wraps mod 2^32)
//   o_wait_cycles  : memory wait cycles  (wraps mod 2^32)
module arb_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inst_grant,
  input  logic        i_data_grant,
  input  logic        i_wait_cycle,
  output logic [31:0] o_i_grants,
  output logic [31:0] o_d_grants,
  output logic [31:0] o_wait_cycles
);
  logic [31:0] r_i_grants;
  logic [31:0] r_d_grants;
  logic [31:0] r_wait_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_grants    <= '0;
      r_d_grants    <= '0;
      r_wait_cycles <= '0;
    end else begin
      if (i_inst_grant) r_i_grants    <= r_i_grants + 32'd1;
      if (i_data_grant) r_d_grants    <= r_d_grants + 32'd1;
      if (i_wait_cycle) r_wait_cycles <= r_wait_cycles + 32'd1;
    end
  end

  assign o_i_grants    = r_i_grants;
  assign o_d_grants    = r_d_grants;
  assign o_wait_cycles = r_wait_cycles;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the
// core's instruction-fetch port and data port. Data has fixed priority; a
// streak counter forces a fetch grant after STARVE_MAX consecutive data
// grants while a fetch is pending. One access in flight at a time.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : fetch port, data port and memory port (mem_arbiter_if)
//   o_state         : current FSM state (debug)
//   o_d_streak      : consecutive data grants while fetch waits (debug)
//   perf_i_grants, perf_d_grants, perf_wait_cycles :
//                     present only when MEM_ARBITER_PERF_EN is defined
//
// Optional feature macro: MEM_ARBITER_PERF_EN
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,   // must match the bus instance
  parameter int DW         = DW_DEF,   // must match the bus instance
  parameter int STARVE_MAX = 4         // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output arb_state_e          o_state,
  output logic [STREAK_W-1:0] o_d_streak
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]         perf_i_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_wait_cycles
`endif
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  arb_state_e          r_state,      w_state_nxt;
  logic [STREAK_W-1:0] r_d_streak,   w_d_streak_nxt;
  logic                r_mem_req,    w_mem_req_nxt;
  logic                r_mem_wen,    w_mem_wen_nxt;
  logic [AW-1:0]       r_mem_addr,   w_mem_addr_nxt;
  logic [DW-1:0]       r_mem_wdata,  w_mem_wdata_nxt;
  logic                r_i_ready,    w_i_ready_nxt;
  logic [DW-1:0]       r_i_rdata,    w_i_rdata_nxt;
  logic                r_d_ready,    w_d_ready_nxt;
  logic [DW-1:0]       r_d_rdata,    w_d_rdata_nxt;
  logic                w_grant_i;
  logic                w_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Abandons any in-flight access; it is not retried afterwards.
      r_state     <= IDLE;
      r_d_streak  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_d_streak  <= w_d_streak_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_wen   <= w_mem_wen_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  always_comb begin
    // Memory fields hold by default; ready pulses and read data default low.
    w_state_nxt     = r_state;
    w_d_streak_nxt  = r_d_streak;
    w_mem_req_nxt   = r_mem_req;
    w_mem_wen_nxt   = r_mem_wen;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_i_ready_nxt   = 1'b0;
    w_i_rdata_nxt   = '0;
    w_d_ready_nxt   = 1'b0;
    w_d_rdata_nxt   = '0;
    w_grant_i       = 1'b0;
    w_grant_d       = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Data wins unless the fetch has waited through a full streak.
        if (bus.i_req && (!bus.d_req || r_d_streak == STREAK_MAX)) begin
          w_grant_i = 1'b1;
        end else if (bus.d_req) begin
          w_grant_d = 1'b1;
        end

        if (w_grant_i) begin
          w_state_nxt     = BUSY_I;
          w_mem_req_nxt   = 1'b1;
          w_mem_wen_nxt   = 1'b0;
          w_mem_addr_nxt  = bus.i_addr;
          w_mem_wdata_nxt = '0;
        end else if (w_grant_d) begin
          w_state_nxt     = BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_wen_nxt   = bus.d_wen;
          w_mem_addr_nxt  = bus.d_addr;
          w_mem_wdata_nxt = bus.d_wdata;
        end

        // The streak only measures how long a pending fetch has been passed over.
        if (w_grant_i || !bus.i_req) begin
          w_d_streak_nxt = '0;
        end else if (w_grant_d && r_d_streak != STREAK_MAX) begin
          w_d_streak_nxt = r_d_streak + 1'b1;
        end
      end

      BUSY_I: begin
        if (bus.mem_ready) begin
          w_mem_req_nxt = 1'b0;
          w_i_ready_nxt = 1'b1;
          w_i_rdata_nxt = bus.mem_rdata;
          w_state_nxt   = RESP;
        end
      end

      BUSY_D: begin
        if (bus.mem_ready) begin
          w_mem_req_nxt = 1'b0;
          w_d_ready_nxt = 1'b1;
          w_d_rdata_nxt = r_mem_wen ? '0 : bus.mem_rdata;
          w_state_nxt   = RESP;
        end
      end

      RESP: begin
        // One dead cycle lets the requester drop its request after the ready
        // pulse, so the same request cannot be granted twice.
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;

  assign o_state    = r_state;
  assign o_d_streak = r_d_streak;

`ifdef MEM_ARBITER_PERF_EN
  arb_perf_cnt u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_inst_grant  (w_grant_i),
    .i_data_grant  (w_grant_d),
    .i_wait_cycle  (r_mem_req && !bus.mem_ready),
    .o_i_grants    (perf_i_grants),
    .o_d_grants    (perf_d_grants),
    .o_wait_cycles (perf_wait_cycles)
  );
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the core's instruction-fetch port and its data port.
- Sits between the RISC-V core and the unified memory model; replaces the separate mem_I/mem_D paths.
- Each requester stalls until its ready pulse.
- Data requests have fixed priority; a streak limit keeps instruction fetch from starving.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_MAX, 4, maximum consecutive D grants while I is pending (legal range 1..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- i_req  input  1  instruction fetch request; held high until i_ready.
- i_addr  input  AW  fetch address; stable while i_req is high.
- i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  DW  fetched word; valid only while i_ready is high.
- d_req  input  1  data request; held high until d_ready.
- d_wen  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_ready  output  1  one-cycle pulse: data access complete.
- d_rdata  output  DW  read data; valid while d_ready is high (0 for writes).
- mem_req  output  1  memory request; held high until mem_ready.
- mem_wen  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; sampled when mem_ready is high.
- mem_ready  input  1  memory completes the current access this cycle.

Behaviour:
- Reset: state IDLE; every output 0; d_streak 0. Applies even mid-transaction: mem_req drops at the next edge and the abandoned access is not retried.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, only d_req: go to BUSY_D.
- IDLE, only i_req: go to BUSY_I.
- IDLE, both pending: go to BUSY_I if d_streak == STARVE_MAX, otherwise BUSY_D.
- On the grant edge, register mem_addr/mem_wen/mem_wdata from the winner and set mem_req = 1. For an I grant, mem_wen = 0 and mem_wdata = 0.
- BUSY_x: hold mem_* stable. On the edge where mem_ready = 1:
  - clear mem_req;
  - register mem_rdata into x_rdata (d_rdata = 0 when d_wen);
  - pulse x_ready for exactly one cycle;
  - go to RESP.
- mem_ready while IDLE or RESP: ignored.
- RESP: unconditionally go to IDLE. This gives the requester one cycle to drop or change its request, so the same request is never granted twice.
- Latency: request seen in IDLE at cycle N → mem_req at N+1 → with zero-wait memory (mem_ready at N+1), x_ready at N+2 → IDLE at N+3. Minimum throughput is 3 cycles per transaction.
- d_streak (4-bit):
  - increments on a D grant while i_req is high;
  - clears on an I grant, or in IDLE when i_req is low;
  - saturates at STARVE_MAX.
- A request that drops before its grant is simply not served. Changing fields while req is high is a protocol violation; the arbiter behaviour is undefined.
- No outstanding-transaction queue: at most one memory access is in flight.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined: adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_wait_cycles[31:0].
  - perf_i_grants / perf_d_grants: count grants.
  - perf_wait_cycles: counts cycles with mem_req = 1 and mem_ready = 0.
  - All wrap modulo 2^32 and clear on rst.
- Not defined: those ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package mem_arbiter_pkg holds:
  - FSM state encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RESP = 2'd3);
  - default AW/DW;
  - the d_streak width constant.
- One sub-module, arb_perf_cnt: holds the three counters, instantiated only under MEM_ARBITER_PERF_EN.
- Grant logic and FSM stay in mem_arbiter.

Test Plan:
- Reset mid-access: i_req, addr 0x10; mem_ready held 0 for 3 cycles; rst = 1 → next edge mem_req = 0, i_ready = 0, state IDLE; no i_ready ever issued for the aborted fetch.
- Single fetch: i_req, addr 0x04, memory returns 0xDEADBEEF with zero wait → mem_req at N+1 with mem_addr 0x04 and mem_wen 0; i_ready pulse at N+2 with i_rdata 0xDEADBEEF; IDLE at N+3.
- Collision: i_req and d_req (write, addr 0x100, data 0x12345678) in the same cycle → D granted first (mem_wen 1, mem_wdata 0x12345678); d_ready pulses with d_rdata 0; I granted next.
- Starvation: i_req held, d_req re-asserted continuously, STARVE_MAX = 4 → exactly 4 D grants, then an I grant; d_streak returns to 0.
- Wait states: d read, addr 0x200, mem_ready delayed 5 cycles with mem_rdata 0xCAFEF00D → mem_req high for 6 cycles with mem_* stable; d_ready one cycle with 0xCAFEF00D. With MEM_ARBITER_PERF_EN: perf_wait_cycles = 5, perf_d_grants = 1.
